// File: rtl/arbitro_entradas.sv
// Front-panel input arbiter: per-channel 3-stage synchronizers, one shared round-robin debounce counter,
// and a single-entry valid/ready press-event register. Define RELEASE_EVT_EN to also report releases (evt_release).
module arbitro_entradas #(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int CNT_W        = 18,
  parameter int ID_W         = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in_async,
  output logic [N_CH-1:0] level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            overflow,
  input  logic            ovf_clr,
`ifdef RELEASE_EVT_EN
  output logic            evt_release,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_CH - 1);

  state_t          state_q;
  logic [N_CH-1:0] sync0_q, sync1_q, sync2_q;
  logic [N_CH-1:0] level_q;
  logic [ID_W-1:0] sel_q, ptr_q, evt_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic            evt_valid_q, ovf_q;
`ifdef RELEASE_EVT_EN
  logic            evt_rel_q;
`endif

  logic [N_CH-1:0] pending_d;
  logic            grant_vld_d, hi_vld_d;
  logic [ID_W-1:0] grant_id_d, hi_id_d, lo_id_d, ptr_d;
  logic            evt_gen_d, evt_drop_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync0_q <= in_async;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
    end
  end

  // Round-robin: smallest pending index >= ptr wins, otherwise wrap to the smallest pending index.
  always_comb begin
    pending_d = sync2_q ^ level_q;
    hi_vld_d  = 1'b0;
    hi_id_d   = '0;
    lo_id_d   = '0;
    grant_vld_d = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        grant_vld_d = 1'b1;
        lo_id_d     = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_vld_d = 1'b1;
          hi_id_d  = ID_W'(i);
        end
      end
    end
    grant_id_d = hi_vld_d ? hi_id_d : lo_id_d;
    ptr_d      = (sel_q == ID_LAST) ? '0 : sel_q + ID_W'(1);
  end

  always_comb begin
`ifdef RELEASE_EVT_EN
    evt_gen_d = (state_q == COMMIT);
`else
    evt_gen_d = (state_q == COMMIT) && !level_q[sel_q];
`endif
    evt_drop_d = evt_gen_d && evt_valid_q && !evt_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ovf_q       <= 1'b0;
`ifdef RELEASE_EVT_EN
      evt_rel_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            sel_q   <= grant_id_d;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          // A level that falls back before the count completes is a glitch; the pointer stays put.
          if (sync2_q[sel_q] != level_q[sel_q]) begin
            if (cnt_q == CNT_LAST) state_q <= COMMIT;
            else                   cnt_q   <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        COMMIT: begin
          level_q[sel_q] <= ~level_q[sel_q];
          ptr_q          <= ptr_d;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (evt_gen_d) begin
        if (!evt_valid_q || evt_ready) begin
          evt_valid_q <= 1'b1;
          evt_id_q    <= sel_q;
`ifdef RELEASE_EVT_EN
          evt_rel_q   <= level_q[sel_q];
`endif
        end
      end else if (evt_valid_q && evt_ready) begin
        evt_valid_q <= 1'b0;
      end

      if (evt_drop_d)   ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign level     = level_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
`ifdef RELEASE_EVT_EN
  assign evt_release = evt_rel_q;
`endif

endmodule

// File: tb/tb_arbitro_entradas.sv
// Directed bench for arbitro_entradas with DEBOUNCE_CYC=4, N_CH=4 (input sampled at edge k -> level at edge k+8).
module tb_arbitro_entradas;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_async = 4'b0000;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       overflow;
  logic       busy;
`ifdef RELEASE_EVT_EN
  logic       evt_release;
`endif

  int checks = 0;
  int errors = 0;

  arbitro_entradas #(.N_CH(4), .DEBOUNCE_CYC(4), .CNT_W(3), .ID_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_async(in_async),
    .level(level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .overflow(overflow),
    .ovf_clr(ovf_clr),
`ifdef RELEASE_EVT_EN
    .evt_release(evt_release),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input logic [3:0] din);
    reset = 1'b0; in_async = din; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_async = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL rst_level got %b want %b", level, 4'b0000); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got %b want 0", evt_valid); end
    checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL rst_evt_id got %0d want 0", evt_id); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    evt_ready = 1'b1;
    reset = 1'b1;
    tick(8);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL init_level_e7 got %b want %b", level, 4'b0000); end
    tick(1);
    checks++; if (level !== 4'b0001) begin errors++; $display("FAIL init_level_ch0 got %b want %b", level, 4'b0001); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL init_evt_ch0 got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
    tick(6);
    checks++; if (level !== 4'b0011) begin errors++; $display("FAIL init_level_ch1 got %b want %b", level, 4'b0011); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin errors++; $display("FAIL init_evt_ch1 got v=%b id=%0d want v=1 id=1", evt_valid, evt_id); end
    tick(6);
    checks++; if (level !== 4'b0111) begin errors++; $display("FAIL init_level_ch2 got %b want %b", level, 4'b0111); end
    tick(6);
    checks++; if (level !== 4'b1111) begin errors++; $display("FAIL init_level_ch3 got %b want %b", level, 4'b1111); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL init_overflow got %b want 0", overflow); end
    evt_ready = 1'b0;
  endtask

  task automatic test_press_release;
    apply_reset(4'b0000);
    in_async = 4'b0100;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_k2 got %b want 0", busy); end
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL press_busy_k3 got %b want 1", busy); end
    tick(4);
    checks++; if (level !== 4'b0000 || evt_valid !== 1'b0) begin errors++; $display("FAIL press_early got level=%b v=%b want 0000 0", level, evt_valid); end
    tick(1);
    checks++; if (level !== 4'b0100) begin errors++; $display("FAIL press_level got %b want %b", level, 4'b0100); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL press_evt got v=%b id=%0d want v=1 id=2", evt_valid, evt_id); end
`ifdef RELEASE_EVT_EN
    checks++; if (evt_release !== 1'b0) begin errors++; $display("FAIL press_kind got %b want 0", evt_release); end
`endif
    evt_ready = 1'b1;
    tick(1);
    checks++; if (evt_valid !== 1'b0 || evt_id !== 2'd2) begin errors++; $display("FAIL press_accept got v=%b id=%0d want v=0 id=2", evt_valid, evt_id); end
    in_async = 4'b0000;
    tick(8);
    checks++; if (level !== 4'b0100) begin errors++; $display("FAIL release_early got %b want %b", level, 4'b0100); end
    tick(1);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL release_level got %b want %b", level, 4'b0000); end
`ifdef RELEASE_EVT_EN
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_release !== 1'b1) begin errors++; $display("FAIL release_evt got v=%b id=%0d rel=%b want 1 2 1", evt_valid, evt_id, evt_release); end
`else
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL release_no_evt got %b want 0", evt_valid); end
`endif
    evt_ready = 1'b0;
  endtask

  task automatic test_glitch;
    apply_reset(4'b0000);
    in_async = 4'b0010;
    tick(2);
    in_async = 4'b0000;
    tick(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_k4 got %b want 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_k5 got %b want 0", busy); end
    tick(10);
    checks++; if (level !== 4'b0000 || evt_valid !== 1'b0) begin errors++; $display("FAIL glitch_quiet got level=%b v=%b want 0000 0", level, evt_valid); end
    // ptr still 0, so ch1 must win over ch3
    in_async = 4'b1010;
    tick(9);
    checks++; if (level !== 4'b0010) begin errors++; $display("FAIL glitch_ptr_level got %b want %b", level, 4'b0010); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin errors++; $display("FAIL glitch_ptr_evt got v=%b id=%0d want v=1 id=1", evt_valid, evt_id); end
  endtask

  task automatic test_overflow;
    apply_reset(4'b0000);
    in_async = 4'b1001;
    tick(9);
    checks++; if (level !== 4'b0001 || evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL ovf_first got level=%b v=%b id=%0d want 0001 1 0", level, evt_valid, evt_id); end
    tick(5);
    checks++; if (overflow !== 1'b0 || level !== 4'b0001) begin errors++; $display("FAIL ovf_early got ovf=%b level=%b want 0 0001", overflow, level); end
    ovf_clr = 1'b1;
    tick(1);
    checks++; if (level !== 4'b1001) begin errors++; $display("FAIL ovf_level got %b want %b", level, 4'b1001); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_prio got %b want 1", overflow); end
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL ovf_kept got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
    tick(1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    apply_reset(4'b0000);
    in_async = 4'b1001;
    tick(14);
    evt_ready = 1'b1;
    tick(1);
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin errors++; $display("FAIL b2b_evt got v=%b id=%0d want v=1 id=3", evt_valid, evt_id); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    tick(1);
    checks++; if (evt_valid !== 1'b0 || evt_id !== 2'd3) begin errors++; $display("FAIL b2b_drain got v=%b id=%0d want v=0 id=3", evt_valid, evt_id); end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_count;
    apply_reset(4'b0000);
    in_async = 4'b0010;
    tick(6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_counting got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || level !== 4'b0000 || evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got busy=%b level=%b v=%b want 0 0000 0", busy, level, evt_valid); end
    tick(1);
    reset = 1'b1;
    tick(8);
    checks++; if (level !== 4'b0000 || evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got level=%b v=%b want 0000 0", level, evt_valid); end
    tick(1);
    checks++; if (level !== 4'b0010 || evt_valid !== 1'b1 || evt_id !== 2'd1) begin errors++; $display("FAIL midrst_redebounce got level=%b v=%b id=%0d want 0010 1 1", level, evt_valid, evt_id); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
